// File: rtl/sbtel_pkg.sv
// Shared types and opcode constants for the memory-access stage and its
// neighbours.
// EX_MEM is the record handed over by execute. EX_WB is the record handed to
// writeback. Both use big-endian bit numbering, so bit 0 is the MSB.
// The helpers classify an opcode as load or store, and project an EX_MEM
// record onto the EX_WB fields.
package sbtel_pkg;

  localparam logic [0:7] OP_LOAD        = 8'd139;  // MOV r,m
  localparam logic [0:7] OP_STORE       = 8'd137;  // MOV m,r
  localparam logic [0:7] OP_PUSH_LO     = 8'd80;   // PUSH 80..87
  localparam logic [0:7] OP_POP_LO      = 8'd88;   // POP  88..95
  localparam logic [0:7] OP_PUSH_POP_HI = 8'd95;
  localparam logic [0:7] OP_CALL        = 8'd232;
  localparam logic [0:7] OP_CALLIND     = 8'd255;
  localparam logic [0:7] OP_RETQ        = 8'd195;

  typedef struct packed {
    logic [0:63] pc_contents;
    logic [0:63] alu_result;
    logic [0:63] alu_ext_result;
    logic [0:63] mem_addr;
    logic [0:63] store_data;
    logic [0:7]  ctl_opcode;
    logic [0:3]  ctl_regByte;
    logic [0:3]  ctl_rmByte;
    logic        sim_end;
  } EX_MEM;

  typedef struct packed {
    logic [0:63] pc_contents;
    logic [0:63] alu_result;
    logic [0:63] alu_ext_result;
    logic [0:7]  ctl_opcode;
    logic [0:3]  ctl_regByte;
    logic [0:3]  ctl_rmByte;
    logic        sim_end;
  } EX_WB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } memport_state_t;

  // POP occupies the whole 88..95 block; PUSH is the block just below it.
  function automatic logic is_load_op(input logic [0:7] op);
    return (op == OP_LOAD) || (op == OP_RETQ) ||
           ((op >= OP_POP_LO) && (op <= OP_PUSH_POP_HI));
  endfunction

  function automatic logic is_store_op(input logic [0:7] op);
    return (op == OP_STORE) || (op == OP_CALL) || (op == OP_CALLIND) ||
           ((op >= OP_PUSH_LO) && (op < OP_POP_LO));
  endfunction

  function automatic EX_WB to_ex_wb(input EX_MEM m);
    EX_WB w;
    w.pc_contents    = m.pc_contents;
    w.alu_result     = m.alu_result;
    w.alu_ext_result = m.alu_ext_result;
    w.ctl_opcode     = m.ctl_opcode;
    w.ctl_regByte    = m.ctl_regByte;
    w.ctl_rmByte     = m.ctl_rmByte;
    w.sim_end        = m.sim_end;
    return w;
  endfunction

endpackage

// File: rtl/mod_memport_fsm.sv
// Request/response handshake FSM for the memory port.
// A start pulse in IDLE latches the address, data and direction. The FSM then
// moves to REQ.
// REQ holds the request stable until mem_req_ready. A store then completes.
// A load moves on to WAIT.
// WAIT completes on mem_resp_valid. mem_resp_valid is ignored in every other
// state.
// Ports:
//   start, start_write, start_addr, start_data : new access from the stage
//   idle                                       : FSM can accept a new access
//   mem_req_*                                  : request side of memory port
//   mem_resp_valid                             : load data is present
//   store_done, load_done : combinational completion strobes. Each is high
//                           during the cycle whose closing edge completes the
//                           access.
module mod_memport_fsm
  import sbtel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        start_write,
  input  logic [0:63] start_addr,
  input  logic [0:63] start_data,
  output logic        idle,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [0:63] mem_req_addr,
  output logic [0:63] mem_req_data,
  input  logic        mem_resp_valid,
  output logic        store_done,
  output logic        load_done
);

  memport_state_t state_q, state_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_req_write <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req_write <= start_write;
        mem_req_addr  <= start_addr;
        mem_req_data  <= start_data;
      end
    end
  end

  // NOTE: every output gets a default before the case, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    idle          = 1'b0;
    mem_req_valid = 1'b0;
    store_done    = 1'b0;
    load_done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        idle = 1'b1;
        if (start) state_d = ST_REQ;
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          if (mem_req_write) begin
            store_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          load_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mod_memstage.sv
// Memory-access pipeline stage that sits between execute and writeback.
// The opcode of each accepted EX_MEM record picks one of three classes:
//   load         : exwb.alu_result is replaced by the memory response
//   store        : writes store_data to mem_addr
//   pass-through : fields are copied straight into exwb
// can_writeback pulses for one cycle when exwb holds a new record.
// store_memstage_active pulses together with it, but only for stores.
// Ports:
//   exmem, exmem_valid, exmem_ready : execute handshake. Ready only when IDLE.
//   mem_req_*, mem_resp_*           : valid/ready memory port
//   exwb, can_writeback, store_memstage_active : registered writeback outputs
module mod_memstage
  import sbtel_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  EX_MEM       exmem,
  input  logic        exmem_valid,
  output logic        exmem_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [0:63] mem_req_addr,
  output logic [0:63] mem_req_data,
  input  logic        mem_resp_valid,
  input  logic [0:63] mem_resp_data,
  output EX_WB        exwb,
  output logic        can_writeback,
  output logic        store_memstage_active
);

  logic fsm_idle;
  logic is_ld;
  logic is_st;
  logic accept;
  logic mem_start;
  logic pass_start;
  logic store_done;
  logic load_done;
  EX_WB held_q;  // writeback fields of the in-flight memory instruction

  assign is_ld = is_load_op(exmem.ctl_opcode);
  assign is_st = is_store_op(exmem.ctl_opcode);

  // While reset is high the FSM is forced to IDLE, so ready is already true.
  // Nothing is accepted until reset is released.
  assign exmem_ready = fsm_idle || reset;
  assign accept      = exmem_valid && fsm_idle && !reset;
  assign mem_start   = accept && (is_ld || is_st);
  assign pass_start  = accept && !(is_ld || is_st);

  mod_memport_fsm u_memport_fsm (
    .clk            (clk),
    .reset          (reset),
    .start          (mem_start),
    .start_write    (is_st),
    .start_addr     (exmem.mem_addr),
    .start_data     (exmem.store_data),
    .idle           (fsm_idle),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .store_done     (store_done),
    .load_done      (load_done)
  );

  // pass_start and the done strobes are mutually exclusive. pass_start needs
  // an idle FSM, and both done strobes need a busy one.
  always_ff @(posedge clk) begin
    if (reset) begin
      exwb                  <= '0;
      held_q                <= '0;
      can_writeback         <= 1'b0;
      store_memstage_active <= 1'b0;
    end else begin
      can_writeback         <= 1'b0;
      store_memstage_active <= 1'b0;
      if (mem_start) held_q <= to_ex_wb(exmem);
      if (pass_start) begin
        exwb          <= to_ex_wb(exmem);
        can_writeback <= 1'b1;
      end else if (store_done) begin
        exwb                  <= held_q;
        can_writeback         <= 1'b1;
        store_memstage_active <= 1'b1;
      end else if (load_done) begin
        exwb            <= held_q;
        exwb.alu_result <= mem_resp_data;
        can_writeback   <= 1'b1;
      end
    end
  end

endmodule
